// File: rtl/player_motion_engine.sv
// Steps the X/Y sprite positions of NUM_PLAYERS players once per game tick.
// Every candidate step is checked against the stage tile map before it is committed.
module player_motion_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 9,
  parameter int SPEED_W     = 5,
  parameter int TILE_SHIFT  = 4,
  parameter int X_MIN       = 72,
  parameter int X_MAX       = 232,
  parameter int Y_MIN       = 32,
  parameter int Y_MAX       = 192
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             tick,
  input  logic [NUM_PLAYERS-1:0]           xmov,
  input  logic [NUM_PLAYERS-1:0]           xdir,
  input  logic [NUM_PLAYERS-1:0]           ymov,
  input  logic [NUM_PLAYERS-1:0]           ydir,
  input  logic [NUM_PLAYERS*SPEED_W-1:0]   speed,
  input  logic [NUM_PLAYERS*COORD_W-1:0]   start_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]   start_y,
  output logic [NUM_PLAYERS*COORD_W-1:0]   pos_x,
  output logic [NUM_PLAYERS*COORD_W-1:0]   pos_y,
  output logic [NUM_PLAYERS-1:0]           moved,
  output logic                             busy,
  output logic                             overrun,
  output logic                             blk_query_valid,
  output logic [COORD_W-TILE_SHIFT-1:0]    blk_tile_x,
  output logic [COORD_W-TILE_SHIFT-1:0]    blk_tile_y,
  input  logic                             blk_resp_valid,
  input  logic                             blk_blocked
);

  localparam int EW = COORD_W + 1;
  localparam int TW = COORD_W - TILE_SHIFT;
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  localparam logic [EW-1:0] XLO     = EW'(X_MIN);
  localparam logic [EW-1:0] XHI     = EW'(X_MAX);
  localparam logic [EW-1:0] YLO     = EW'(Y_MIN);
  localparam logic [EW-1:0] YHI     = EW'(Y_MAX);
  localparam logic [EW-1:0] TILE_M1 = EW'((1 << TILE_SHIFT) - 1);
  localparam logic [PW-1:0] LAST_P  = PW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {IDLE, CALC, WAIT, DONE} state_t;

  state_t               state;
  logic [PW-1:0]        p;
  logic [COORD_W-1:0]   px [NUM_PLAYERS];
  logic [COORD_W-1:0]   py [NUM_PLAYERS];

  // Move controls captured at the tick; inputs are ignored until the next one.
  logic [NUM_PLAYERS-1:0] xmov_s, xdir_s, ymov_s, ydir_s;
  logic [SPEED_W-1:0]     spd_s [NUM_PLAYERS];

  logic [COORD_W-1:0]   cand_r;
  logic                 axis_x;

  // Candidate computation for the player currently in CALC.
  logic                 use_x, use_any, dir, step;
  logic [COORD_W-1:0]   cur, other;
  logic [EW-1:0]        lo, hi, other_lo, spd_e, sum, cand_e, lead;
  logic [TW-1:0]        mtile, otile;

  // NOTE: every always_comb output is given a value on all paths, so no latches form.
  always_comb begin
    use_x    = xmov_s[p];
    use_any  = xmov_s[p] | ymov_s[p];
    dir      = use_x ? xdir_s[p] : ydir_s[p];
    cur      = use_x ? px[p] : py[p];
    other    = use_x ? py[p] : px[p];
    lo       = use_x ? XLO : YLO;
    hi       = use_x ? XHI : YHI;
    other_lo = use_x ? YLO : XLO;
    spd_e    = EW'(spd_s[p]);
    sum      = {1'b0, cur} + spd_e;
    if (dir) cand_e = (sum > hi) ? hi : sum;
    else     cand_e = ({1'b0, cur} < lo + spd_e) ? lo : {1'b0, cur} - spd_e;
    // Leading edge is the far side of the sprite when moving up the axis.
    lead     = dir ? cand_e + TILE_M1 : cand_e;
    mtile    = TW'((lead - lo) >> TILE_SHIFT);
    otile    = TW'(({1'b0, other} - other_lo) >> TILE_SHIFT);
    step     = use_any && (cand_e != {1'b0, cur});
  end

  // NOTE: all state below is updated with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      p               <= '0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      moved           <= '0;
      blk_query_valid <= 1'b0;
      blk_tile_x      <= '0;
      blk_tile_y      <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        px[i] <= start_x[i*COORD_W +: COORD_W];
        py[i] <= start_y[i*COORD_W +: COORD_W];
      end
      // NOTE: snapshot and candidate registers are always written before use, so they carry no reset.
    end else begin
      moved   <= '0;
      overrun <= tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (tick) begin
            xmov_s <= xmov;
            xdir_s <= xdir;
            ymov_s <= ymov;
            ydir_s <= ydir;
            for (int i = 0; i < NUM_PLAYERS; i++)
              spd_s[i] <= speed[i*SPEED_W +: SPEED_W];
            p     <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (step) begin
            cand_r          <= cand_e[COORD_W-1:0];
            axis_x          <= use_x;
            blk_tile_x      <= use_x ? mtile : otile;
            blk_tile_y      <= use_x ? otile : mtile;
            blk_query_valid <= 1'b1;
            state           <= WAIT;
          end else if (p == LAST_P) begin
            state <= DONE;
          end else begin
            p <= p + 1'b1;
          end
        end
        WAIT: begin
          if (blk_resp_valid) begin
            blk_query_valid <= 1'b0;
            if (!blk_blocked) begin
              if (axis_x) px[p] <= cand_r;
              else        py[p] <= cand_r;
              moved[p] <= 1'b1;
            end
            if (p == LAST_P) begin
              state <= DONE;
            end else begin
              p     <= p + 1'b1;
              state <= CALC;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign pos_x[g*COORD_W +: COORD_W] = px[g];
    assign pos_y[g*COORD_W +: COORD_W] = py[g];
  end

endmodule

// File: tb/tb_player_motion_engine.sv
// Directed and randomized checks of player_motion_engine against an arithmetic
// model of the stepping, saturation, tile-query and commit rules.
module tb_player_motion_engine;

  localparam int NP   = 2;
  localparam int CW   = 9;
  localparam int SW   = 5;
  localparam int TW   = 5;
  localparam int XMIN = 72;
  localparam int XMAX = 232;
  localparam int YMIN = 32;
  localparam int YMAX = 192;

  logic               clock = 1'b0;
  logic               reset, tick;
  logic [NP-1:0]      xmov, xdir, ymov, ydir;
  logic [NP*SW-1:0]   speed;
  logic [NP*CW-1:0]   start_x, start_y, pos_x, pos_y;
  logic [NP-1:0]      moved;
  logic               busy, overrun, blk_query_valid;
  logic [TW-1:0]      blk_tile_x, blk_tile_y;
  logic               blk_resp_valid, blk_blocked;

  int errors = 0;
  int checks = 0;

  // Model state: positions and the control set applied at the next tick.
  int mx [NP];
  int my [NP];
  int cspd [NP];
  bit cxm [NP];
  bit cxd [NP];
  bit cym [NP];
  bit cyd [NP];

  player_motion_engine dut (
    .clock(clock), .reset(reset), .tick(tick),
    .xmov(xmov), .xdir(xdir), .ymov(ymov), .ydir(ydir),
    .speed(speed), .start_x(start_x), .start_y(start_y),
    .pos_x(pos_x), .pos_y(pos_y), .moved(moved),
    .busy(busy), .overrun(overrun),
    .blk_query_valid(blk_query_valid),
    .blk_tile_x(blk_tile_x), .blk_tile_y(blk_tile_y),
    .blk_resp_valid(blk_resp_valid), .blk_blocked(blk_blocked)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag);
    for (int i = 0; i < NP; i++) begin
      check({tag, "_x"}, 32'(pos_x[i*CW +: CW]), mx[i]);
      check({tag, "_y"}, 32'(pos_y[i*CW +: CW]), my[i]);
    end
  endtask

  function automatic int mcand(input int pos, input int spd, input bit up, input int lo, input int hi);
    if (up) return (pos + spd > hi) ? hi : pos + spd;
    return (pos < lo + spd) ? lo : pos - spd;
  endfunction

  task automatic apply_controls();
    for (int i = 0; i < NP; i++) begin
      xmov[i] = cxm[i];
      xdir[i] = cxd[i];
      ymov[i] = cym[i];
      ydir[i] = cyd[i];
      speed[i*SW +: SW] = SW'(cspd[i]);
    end
  endtask

  task automatic clear_controls();
    for (int i = 0; i < NP; i++) begin
      cxm[i] = 0; cxd[i] = 0; cym[i] = 0; cyd[i] = 0; cspd[i] = 0;
    end
  endtask

  task automatic do_reset(input int sx0, input int sx1, input int sy0, input int sy1);
    start_x = {CW'(sx1), CW'(sx0)};
    start_y = {CW'(sy1), CW'(sy0)};
    mx[0] = sx0; mx[1] = sx1; my[0] = sy0; my[1] = sy1;
    reset = 1'b1; tick = 1'b0; blk_resp_valid = 1'b0; blk_blocked = 1'b0;
    step();
    step();
    check_pos("rst_pos");
    check("rst_busy", busy, 0);
    check("rst_query", blk_query_valid, 0);
    check("rst_moved", moved, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tile_x", blk_tile_x, 0);
    check("rst_tile_y", blk_tile_y, 0);
    reset = 1'b0;
  endtask

  // Issues one tick with the current control set and acts as the map arbiter.
  task automatic process_tick(input int lat_max, input int blk_pct, input bit probe);
    bit ux, any, up, blocked;
    int pos, lo, hi, cand, lead, mt, ot, w, lat;
    apply_controls();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("busy_rise", busy, 1);
    xmov = NP'($urandom); xdir = NP'($urandom);
    ymov = NP'($urandom); ydir = NP'($urandom);
    speed = (NP*SW)'($urandom);
    if (probe) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("overrun_pulse", overrun, 1);
      step();
      check("overrun_clear", overrun, 0);
    end
    for (int i = 0; i < NP; i++) begin
      ux   = cxm[i];
      any  = cxm[i] | cym[i];
      up   = ux ? cxd[i] : cyd[i];
      pos  = ux ? mx[i] : my[i];
      lo   = ux ? XMIN : YMIN;
      hi   = ux ? XMAX : YMAX;
      cand = mcand(pos, cspd[i], up, lo, hi);
      if (!any || cand == pos) continue;
      lead = up ? cand + 15 : cand;
      mt   = (lead - lo) / 16;
      ot   = ux ? (my[i] - YMIN) / 16 : (mx[i] - XMIN) / 16;
      w = 0;
      while (blk_query_valid !== 1'b1 && w < 10) begin
        step();
        check("no_stray_moved", moved, 0);
        w++;
      end
      check("query_seen", blk_query_valid, 1);
      check("tile_x", blk_tile_x, ux ? mt : ot);
      check("tile_y", blk_tile_y, ux ? ot : mt);
      lat = $urandom_range(0, lat_max);
      repeat (lat) begin
        step();
        check("query_held", blk_query_valid, 1);
        check("tile_x_held", blk_tile_x, ux ? mt : ot);
      end
      blocked = ($urandom_range(0, 99) < blk_pct);
      blk_resp_valid = 1'b1;
      blk_blocked = blocked;
      step();
      blk_resp_valid = 1'b0;
      blk_blocked = 1'b0;
      check("query_drop", blk_query_valid, 0);
      if (!blocked) begin
        if (ux) mx[i] = cand;
        else    my[i] = cand;
      end
      check("moved_mask", moved, blocked ? 0 : (1 << i));
      check_pos("commit");
    end
    w = 0;
    while (busy !== 1'b0 && w < 10) begin
      step();
      check("no_stray_moved", moved, 0);
      w++;
    end
    check("busy_fall", busy, 0);
    check("idle_query", blk_query_valid, 0);
    check_pos("after_tick");
    step();
    check("stay_idle", busy, 0);
    check_pos("no_extra_step");
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; blk_resp_valid = 1'b0; blk_blocked = 1'b0;
    start_x = '0; start_y = '0;
    clear_controls();
    apply_controls();

    // Reset and a rightward step of player 0 answered after three cycles.
    do_reset(72, 232, 96, 96);
    cxm[0] = 1; cxd[0] = 1; cspd[0] = 2;
    cxm[1] = 1; cxd[1] = 1; cspd[1] = 2;
    apply_controls();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("d1_busy", busy, 1);
    check("d1_calc_no_query", blk_query_valid, 0);
    step();
    check("d1_query", blk_query_valid, 1);
    check("d1_tile_x", blk_tile_x, 1);
    check("d1_tile_y", blk_tile_y, 4);
    repeat (3) begin
      step();
      check("d1_query_held", blk_query_valid, 1);
      check("d1_tile_held", blk_tile_x, 1);
    end
    blk_resp_valid = 1'b1;
    blk_blocked = 1'b0;
    step();
    blk_resp_valid = 1'b0;
    check("d1_query_drop", blk_query_valid, 0);
    check("d1_pos_x0", pos_x[CW-1:0], 74);
    check("d1_moved", moved, 1);
    mx[0] = 74;
    step();
    check("d1_moved_once", moved, 0);
    check("d1_p1_no_query", blk_query_valid, 0);
    check("d1_done_busy", busy, 1);
    step();
    check("d1_idle", busy, 0);
    check_pos("d1_final");

    // Leftward step clamped to X_MIN, first answered blocked, then free.
    do_reset(73, 232, 96, 96);
    clear_controls();
    cxm[0] = 1; cxd[0] = 0; cspd[0] = 4;
    apply_controls();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("d2_query", blk_query_valid, 1);
    check("d2_tile_x", blk_tile_x, 0);
    check("d2_tile_y", blk_tile_y, 4);
    blk_resp_valid = 1'b1;
    blk_blocked = 1'b1;
    step();
    blk_resp_valid = 1'b0;
    blk_blocked = 1'b0;
    check("d2_query_drop", blk_query_valid, 0);
    check("d2_blocked_moved", moved, 0);
    check("d2_blocked_pos", pos_x[CW-1:0], 73);
    check("d2_continues", busy, 1);
    step();
    step();
    check("d2_idle", busy, 0);
    process_tick(0, 0, 0);
    check("d2_clamped", pos_x[CW-1:0], 72);
    process_tick(0, 0, 0);

    // Both axes requested: only X moves. Second tick while busy overruns.
    clear_controls();
    cxm[0] = 1; cxd[0] = 1; cym[0] = 1; cyd[0] = 1; cspd[0] = 5;
    cym[1] = 1; cyd[1] = 0; cspd[1] = 3;
    process_tick(2, 0, 1);
    check("d3_x_only_y", pos_y[CW-1:0], 96);

    // Best-case timing with everyone stationary.
    clear_controls();
    apply_controls();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("idle_t1", busy, 1);
    step();
    check("idle_t2", busy, 1);
    step();
    check("idle_t3", busy, 1);
    step();
    check("idle_t4", busy, 0);

    // Reset during WAIT; a late response must be ignored.
    cxm[0] = 1; cxd[0] = 1; cspd[0] = 2;
    apply_controls();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("d4_query", blk_query_valid, 1);
    start_x = {CW'(200), CW'(100)};
    start_y = {CW'(180), CW'(50)};
    mx[0] = 100; mx[1] = 200; my[0] = 50; my[1] = 180;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("d4_query_abandoned", blk_query_valid, 0);
    check("d4_busy_clear", busy, 0);
    check_pos("d4_reset_pos");
    blk_resp_valid = 1'b1;
    blk_blocked = 1'b0;
    step();
    blk_resp_valid = 1'b0;
    check("d4_late_moved", moved, 0);
    check("d4_late_query", blk_query_valid, 0);
    check_pos("d4_late_pos");

    // Randomized ticks against the model.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NP; i++) begin
        cxm[i]  = 1'($urandom_range(0, 1));
        cxd[i]  = 1'($urandom_range(0, 1));
        cym[i]  = 1'($urandom_range(0, 1));
        cyd[i]  = 1'($urandom_range(0, 1));
        cspd[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
      end
      process_tick(3, 30, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
